// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// fetch_stage
// Instruction fetch front end. Issues word-aligned fetch requests to
// instruction memory, collects the in-order responses in a two-entry
// FIFO and presents the oldest instruction to decode. Redirects flush
// the FIFO and discard every response still in flight.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous reset, active low
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts request
//   imem_req_addr    fetch address (always pc)
//   imem_resp_valid  in-order response valid, always accepted
//   imem_resp_data   fetched instruction word
//   redirect_valid   single-cycle redirect pulse
//   redirect_pc      redirect target (low two bits ignored)
//   if_valid         instr_reg / ifid_npc hold a valid instruction
//   id_ready         decode accepts the instruction
//   instr_reg        instruction to decode (bubble 0x000000FF when empty)
//   ifid_npc         address of instr_reg plus 4 (0 when empty)
//
// state | meaning
// BOOT  | first cycle after reset, no requests, redirects ignored
// RUN   | fetching, responses written to the buffer
// FLUSH | waiting for stale in-flight responses, each one is dropped
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] instr_reg,
    output logic [63:0] ifid_npc
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [1:0]  outstanding, outstanding_nxt;
    logic [1:0]  drop_cnt, drop_cnt_nxt;
    logic [1:0]  count, count_nxt;
    logic        head, head_nxt;

    logic [31:0] buf_instr [2];
    logic [63:0] buf_npc   [2];

    logic        redirect_take;
    logic        resp_in;
    logic        resp_keep;
    logic [63:0] resp_npc;
    logic        hs;
    logic        bypass;
    logic        pop;
    logic        pop_buf;
    logic        wr;
    logic        wr_idx;
    logic [1:0]  inflight_after;

    // Requests in RUN are contiguous and all valid (stale ones are drained in
    // FLUSH before any new request), so the oldest outstanding request was
    // issued at pc - 4*outstanding.
    assign resp_npc = pc - {60'b0, outstanding, 2'b00} + 64'd4;

    always_comb begin
        redirect_take  = redirect_valid & (state != BOOT);
        resp_in        = imem_resp_valid & (outstanding != 2'd0);
        resp_keep      = resp_in & (state == RUN) & ~redirect_take;
        inflight_after = outstanding - {1'b0, resp_in};

        imem_req_valid = (state == RUN) & ~redirect_valid &
                         (({1'b0, outstanding} + {1'b0, count}) < 3'(BUF_DEPTH));
        imem_req_addr  = pc;
        hs             = imem_req_valid & imem_req_ready;

        // An arriving response is visible to decode in the same cycle when
        // the buffer is empty.
        bypass    = resp_keep & (count == 2'd0);
        if_valid  = (count != 2'd0) | bypass;
        instr_reg = 32'h0000_00FF;
        ifid_npc  = 64'h0;
        if (count != 2'd0) begin
            instr_reg = buf_instr[head];
            ifid_npc  = buf_npc[head];
        end else if (bypass) begin
            instr_reg = imem_resp_data;
            ifid_npc  = resp_npc;
        end

        pop     = if_valid & id_ready & ~redirect_take;
        pop_buf = pop & (count != 2'd0);
        wr      = resp_keep & ~(bypass & pop);
        wr_idx  = head ^ count[0];

        state_nxt       = state;
        pc_nxt          = pc;
        outstanding_nxt = outstanding;
        drop_cnt_nxt    = drop_cnt;
        count_nxt       = count + {1'b0, wr} - {1'b0, pop_buf};
        head_nxt        = head ^ pop_buf;

        case (state)
            BOOT: state_nxt = RUN;
            RUN, FLUSH: begin
                if (redirect_take) begin
                    pc_nxt          = redirect_pc & ~64'h3;
                    outstanding_nxt = inflight_after;
                    drop_cnt_nxt    = inflight_after;
                    count_nxt       = 2'd0;
                    head_nxt        = head;
                    state_nxt       = (inflight_after != 2'd0) ? FLUSH : RUN;
                end else if (state == RUN) begin
                    if (hs) pc_nxt = pc + 64'd4;
                    outstanding_nxt = outstanding + {1'b0, hs} - {1'b0, resp_in};
                end else begin
                    if (resp_in) begin
                        outstanding_nxt = outstanding - 2'd1;
                        drop_cnt_nxt    = drop_cnt - 2'd1;
                    end
                    if (drop_cnt_nxt == 2'd0) state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            count       <= 2'd0;
            head        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
            count       <= count_nxt;
            head        <= head_nxt;
        end
    end

    // Entry contents need no reset; count gates their visibility.
    always_ff @(posedge clk) begin
        if (wr) begin
            buf_instr[wr_idx] <= imem_resp_data;
            buf_npc[wr_idx]   <= resp_npc;
        end
    end

endmodule
